program_loader: RTL and testbench
=================================

# program_loader

Upstream feeder for the BIP `cpu`. Receives a byte stream from the UART receiver and assembles 16-bit instruction words, low byte first. Writes the words sequentially into program memory from address 0 and holds the CPU in reset meanwhile. Releases the CPU once the HLT instruction has been stored, and re-arms for a new program on request.

## Interface
- `NBITS_O`, 11, program-memory address width (matches CPU `o_PmAddr`)
- `NBITS_D`, 16, instruction width
- `OPCODE`, 5, opcode field width; opcode = instruction[NBITS_D-1 -: OPCODE]
- `NBITS_B`, 8, byte width of receive stream; NBITS_D = 2*NBITS_B

Ports:
- `i_clk`  in  1  single clock
- `i_reset`  in  1  asynchronous, active-high reset
- `i_RxData`  in  NBITS_B  received byte
- `i_RxValid`  in  1  one-cycle strobe, `i_RxData` valid; may assert every cycle
- `i_Reload`  in  1  one-cycle strobe: discard program, restart loading
- `o_PmWrAddr`  out  NBITS_O  program-memory write address
- `o_PmWrData`  out  NBITS_D  program-memory write data
- `o_PmWe`  out  1  program-memory write enable, one cycle per word
- `o_CpuReset`  out  1  drives CPU `i_reset`; 1 while loading
- `o_Done`  out  1  program loaded, CPU running
- `o_Error`  out  1  load failed (overflow or checksum)
- `o_WordCount`  out  NBITS_O+1  words written in current load

## Operation
- States: S_LOW (await low byte), S_HIGH (await high byte), S_CKSUM (await checksum byte, macro only), S_RUN, S_ERROR.
- Reset and `i_Reload` both go to S_LOW with:
  - address counter = 0, `o_WordCount` = 0
  - `o_CpuReset` = 1, `o_Done` = 0, `o_Error` = 0, `o_PmWe` = 0
  - `o_PmWrAddr` = 0, `o_PmWrData` = 0
- S_LOW with valid byte: latch it as the low byte and go to S_HIGH.
- S_HIGH with valid byte: form word = {high, low}.
  - Register the write: `o_PmWe` = 1, `o_PmWrAddr` = counter, `o_PmWrData` = word.
  - Counter += 1 and `o_WordCount` += 1.
- Next state after a word is written:
  - Opcode == 0 (HLT): S_RUN, or S_CKSUM when the macro is defined.
  - Else, word just written at address 2^NBITS_O-1: S_ERROR (memory full, no HLT).
  - Else: S_LOW.
- S_RUN: `o_CpuReset` = 0, `o_Done` = 1. Received bytes are ignored. No writes.
- S_ERROR: `o_Error` = 1, `o_CpuReset` stays 1. Received bytes are ignored. Only `i_Reload` or reset leaves it.
- `i_Reload` has priority over a simultaneous `i_RxValid`; that byte is discarded.
- `i_Reload` in S_LOW or S_HIGH restarts cleanly; a pending low byte is dropped.
- Reset asserted mid-write clears `o_PmWe` immediately, since reset is asynchronous.

## Timing
- Byte accepted on the rising edge where `i_RxValid` = 1.
- High byte accepted at edge N: `o_PmWe`, address and data are valid during cycle N+1, exactly one cycle.
- Back-to-back bytes at one per cycle are sustained. There is no stall and no ready signal.
- HLT high byte at edge N, no macro: `o_PmWe` = 1 in cycle N+1. In that same cycle N+1, `o_CpuReset` = 0 and `o_Done` = 1.
  - The HLT write and the CPU release coincide. This is safe because the CPU does not fetch address 0 until the first edge after reset release.
- `i_Reload` at edge N: `o_CpuReset` = 1 and `o_Done`/`o_Error` = 0 from cycle N+1.
- All outputs are registered.

## Configuration
- `PROGRAM_LOADER_CKSUM_EN` defined:
  - A running XOR of every accepted program byte is kept, cleared on reset and `i_Reload`.
  - After the HLT word, S_CKSUM accepts one byte.
  - Byte equals the XOR: go to S_RUN one cycle later.
  - Byte differs: go to S_ERROR.
  - `o_CpuReset` stays 1 until the match.
- Not defined: no S_CKSUM state and no XOR register. HLT leads directly to S_RUN.

## Structure
- Shared package `bip_pkg`:
  - state encoding for the loader FSM
  - `HLT_OPCODE` = 5'b00000
  - opcode field position constants, shared with `control`
- One sub-module is natural: `loader_cksum`, the XOR accumulator with clear and enable. It is instantiated only under `PROGRAM_LOADER_CKSUM_EN`. All other logic lives in a single flat FSM.

## Test plan
- **Reset:** `i_reset` pulsed → `o_CpuReset` = 1, `o_Done` = 0, `o_Error` = 0, `o_PmWe` = 0, `o_WordCount` = 0.
- **Three-word program, back-to-back bytes:** bytes 0x05,0x08 / 0x03,0x10 / 0x00,0x00.
  - Three `o_PmWe` pulses: addr 0 data 0x0805, addr 1 data 0x1003, addr 2 data 0x0000.
  - `o_Done` = 1 in the same cycle as the third write; `o_WordCount` = 3.
- **Gapped bytes with reload:** valid strobes 5 cycles apart → same writes as the previous scenario. Then bytes ignored in S_RUN, with no `o_PmWe`. `i_Reload` → `o_CpuReset` = 1 next cycle; reload of 0x00,0x00 writes addr 0.
- **Overflow:** 2048 words with opcode ≠ 0 (e.g. 0x0801) → last write at addr 0x7FF, then `o_Error` = 1 and `o_CpuReset` stays 1. `i_Reload` clears `o_Error`.
- **Reload during high phase:** low byte 0x05, then `i_Reload` together with `i_RxValid` (byte 0x08) → no write, state S_LOW. The next pair 0x00,0x00 writes addr 0 data 0x0000.
- **Checksum (macro on):** bytes 0x05,0x08,0x00,0x00 then 0x0D → `o_Done` = 1. Same program with checksum 0x0C → `o_Error` = 1, `o_CpuReset` = 1.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared BIP definitions: loader FSM encoding and instruction opcode field layout.
package bip_pkg;

    typedef enum logic [2:0] {
        S_LOW   = 3'd0,
        S_HIGH  = 3'd1,
        S_CKSUM = 3'd2,
        S_RUN   = 3'd3,
        S_ERROR = 3'd4
    } loader_state_e;

    localparam logic [4:0] HLT_OPCODE = 5'b00000;

    // Opcode occupies the top bits of a 16-bit instruction; also used by control.
    localparam int unsigned INSTR_W    = 16;
    localparam int unsigned OPCODE_W   = 5;
    localparam int unsigned OPCODE_MSB = INSTR_W - 1;
    localparam int unsigned OPCODE_LSB = INSTR_W - OPCODE_W;

endpackage

// File: rtl/loader_cksum.sv
// Running XOR of accepted program bytes, with synchronous clear and enable.
module loader_cksum #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] data,
    output logic [W-1:0] sum
);

    logic [W-1:0] sum_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
        end else if (clr) begin
            sum_q <= '0;
        end else if (en) begin
            sum_q <= sum_q ^ data;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/program_loader.sv
// Assembles UART bytes (low first) into instruction words, writes them to program memory and
// holds the CPU in reset until HLT is stored. Optional checksum byte: PROGRAM_LOADER_CKSUM_EN.
module program_loader
    import bip_pkg::*;
#(
    parameter int unsigned NBITS_O = 11,
    parameter int unsigned NBITS_D = 16,
    parameter int unsigned OPCODE  = 5,
    parameter int unsigned NBITS_B = 8
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NBITS_B-1:0] i_RxData,
    input  logic               i_RxValid,
    input  logic               i_Reload,
    output logic [NBITS_O-1:0] o_PmWrAddr,
    output logic [NBITS_D-1:0] o_PmWrData,
    output logic               o_PmWe,
    output logic               o_CpuReset,
    output logic               o_Done,
    output logic               o_Error,
    output logic [NBITS_O:0]   o_WordCount
);

    loader_state_e      state_q, state_d;
    logic [NBITS_B-1:0] lo_q, lo_d;
    logic [NBITS_O-1:0] addr_q, addr_d;
    logic [NBITS_O:0]   count_q, count_d;
    logic [NBITS_O-1:0] pm_addr_q, pm_addr_d;
    logic [NBITS_D-1:0] pm_data_q, pm_data_d;
    logic               pm_we_q, pm_we_d;
    logic [NBITS_D-1:0] word;
    logic [OPCODE-1:0]  opcode;

    assign word   = {i_RxData, lo_q};
    assign opcode = word[NBITS_D-1 -: OPCODE];

`ifdef PROGRAM_LOADER_CKSUM_EN
    logic [NBITS_B-1:0] cksum;
    logic               cksum_en;

    assign cksum_en = i_RxValid && !i_Reload && (state_q == S_LOW || state_q == S_HIGH);

    loader_cksum #(
        .W (NBITS_B)
    ) u_cksum (
        .clk  (i_clk),
        .rst  (i_reset),
        .clr  (i_Reload),
        .en   (cksum_en),
        .data (i_RxData),
        .sum  (cksum)
    );

    localparam loader_state_e HLT_NEXT = S_CKSUM;
`else
    localparam loader_state_e HLT_NEXT = S_RUN;
`endif

    always_comb begin
        state_d   = state_q;
        lo_d      = lo_q;
        addr_d    = addr_q;
        count_d   = count_q;
        pm_addr_d = pm_addr_q;
        pm_data_d = pm_data_q;
        pm_we_d   = 1'b0;

        // Reload wins over a same-cycle byte; that byte is dropped.
        if (i_Reload) begin
            state_d   = S_LOW;
            lo_d      = '0;
            addr_d    = '0;
            count_d   = '0;
            pm_addr_d = '0;
            pm_data_d = '0;
        end else if (i_RxValid) begin
            unique case (state_q)
                S_LOW: begin
                    lo_d    = i_RxData;
                    state_d = S_HIGH;
                end
                S_HIGH: begin
                    pm_we_d   = 1'b1;
                    pm_addr_d = addr_q;
                    pm_data_d = word;
                    addr_d    = addr_q + NBITS_O'(1);
                    count_d   = count_q + (NBITS_O + 1)'(1);
                    if (opcode == OPCODE'(HLT_OPCODE)) begin
                        state_d = HLT_NEXT;
                    end else if (addr_q == '1) begin
                        state_d = S_ERROR;
                    end else begin
                        state_d = S_LOW;
                    end
                end
`ifdef PROGRAM_LOADER_CKSUM_EN
                S_CKSUM: begin
                    state_d = (i_RxData == cksum) ? S_RUN : S_ERROR;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q   <= S_LOW;
            lo_q      <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            pm_addr_q <= '0;
            pm_data_q <= '0;
            pm_we_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lo_q      <= lo_d;
            addr_q    <= addr_d;
            count_q   <= count_d;
            pm_addr_q <= pm_addr_d;
            pm_data_q <= pm_data_d;
            pm_we_q   <= pm_we_d;
        end
    end

    assign o_PmWrAddr  = pm_addr_q;
    assign o_PmWrData  = pm_data_q;
    assign o_PmWe      = pm_we_q;
    assign o_WordCount = count_q;
    assign o_CpuReset  = (state_q != S_RUN);
    assign o_Done      = (state_q == S_RUN);
    assign o_Error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: vector table plus write scoreboard.
module tb_program_loader;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_RxData = '0;
    logic        i_RxValid = 1'b0;
    logic        i_Reload = 1'b0;
    logic [10:0] o_PmWrAddr;
    logic [15:0] o_PmWrData;
    logic        o_PmWe;
    logic        o_CpuReset;
    logic        o_Done;
    logic        o_Error;
    logic [11:0] o_WordCount;

    program_loader dut (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_RxData    (i_RxData),
        .i_RxValid   (i_RxValid),
        .i_Reload    (i_Reload),
        .o_PmWrAddr  (o_PmWrAddr),
        .o_PmWrData  (o_PmWrData),
        .o_PmWe      (o_PmWe),
        .o_CpuReset  (o_CpuReset),
        .o_Done      (o_Done),
        .o_Error     (o_Error),
        .o_WordCount (o_WordCount)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0]  lo;
        logic [7:0]  hi;
        logic [15:0] data;
    } vec_t;

    typedef struct {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    vec_t        prog [3];
    wr_t         exp_q [$];
    wr_t         mon_e;
    logic [10:0] exp_addr = '0;
    logic [7:0]  xor_acc = '0;
    int          n_cmp = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Writes are compared against the scoreboard away from the active edge.
    always @(negedge i_clk) begin
        if (!i_reset && o_PmWe) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {21'd0, o_PmWrAddr}, 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", {21'd0, o_PmWrAddr}, {21'd0, mon_e.addr});
                check("wr_data", {16'd0, o_PmWrData}, {16'd0, mon_e.data});
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        i_RxData  = b;
        i_RxValid = 1'b1;
        tick();
        i_RxValid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_word(input logic [7:0] lo, input logic [7:0] hi, input int gap);
        xor_acc = xor_acc ^ lo ^ hi;
        send(lo, gap);
        exp_q.push_back('{addr: exp_addr, data: {hi, lo}});
        exp_addr = exp_addr + 11'd1;
        send(hi, gap);
    endtask

    task automatic end_prog();
`ifdef PROGRAM_LOADER_CKSUM_EN
        send(xor_acc, 0);
`endif
    endtask

    task automatic reload();
        i_Reload = 1'b1;
        tick();
        i_Reload = 1'b0;
        exp_addr = '0;
        xor_acc  = '0;
    endtask

    initial begin
        prog[0] = '{lo: 8'h05, hi: 8'h08, data: 16'h0805};
        prog[1] = '{lo: 8'h03, hi: 8'h10, data: 16'h1003};
        prog[2] = '{lo: 8'h00, hi: 8'h00, data: 16'h0000};

        // Reset state
        tick();
        tick();
        check("rst_cpu_reset", {31'd0, o_CpuReset}, 32'd1);
        check("rst_done", {31'd0, o_Done}, 32'd0);
        check("rst_error", {31'd0, o_Error}, 32'd0);
        check("rst_we", {31'd0, o_PmWe}, 32'd0);
        check("rst_count", {20'd0, o_WordCount}, 32'd0);
        i_reset = 1'b0;
        tick();

        // Three-word program, back-to-back
        for (int i = 0; i < 3; i++) begin
            check("vec_data", {16'd0, prog[i].hi, prog[i].lo}, {16'd0, prog[i].data});
            send_word(prog[i].lo, prog[i].hi, 0);
        end
`ifndef PROGRAM_LOADER_CKSUM_EN
        check("hlt_we_same_cycle", {31'd0, o_PmWe}, 32'd1);
`endif
        end_prog();
        check("b2b_done", {31'd0, o_Done}, 32'd1);
        check("b2b_cpu_reset", {31'd0, o_CpuReset}, 32'd0);
        check("b2b_count", {20'd0, o_WordCount}, 32'd3);

        // Reload, then gapped bytes
        reload();
        check("reload_cpu_reset", {31'd0, o_CpuReset}, 32'd1);
        check("reload_done", {31'd0, o_Done}, 32'd0);
        check("reload_count", {20'd0, o_WordCount}, 32'd0);
        for (int i = 0; i < 3; i++) send_word(prog[i].lo, prog[i].hi, 4);
        end_prog();
        check("gap_done", {31'd0, o_Done}, 32'd1);
        check("gap_count", {20'd0, o_WordCount}, 32'd3);
        for (int i = 0; i < 4; i++) send(8'hA5, 0);
        check("run_ignore_count", {20'd0, o_WordCount}, 32'd3);
        check("run_ignore_done", {31'd0, o_Done}, 32'd1);
        reload();
        check("reload2_cpu_reset", {31'd0, o_CpuReset}, 32'd1);
        send_word(8'h00, 8'h00, 0);
        check("reload2_count", {20'd0, o_WordCount}, 32'd1);

        // Reload together with the high byte: no write, pending low dropped
        reload();
        send(8'h05, 0);
        i_RxData  = 8'h08;
        i_RxValid = 1'b1;
        i_Reload  = 1'b1;
        tick();
        i_RxValid = 1'b0;
        i_Reload  = 1'b0;
        check("rl_hi_we", {31'd0, o_PmWe}, 32'd0);
        check("rl_hi_count", {20'd0, o_WordCount}, 32'd0);
        send_word(8'h00, 8'h00, 0);
        check("rl_hi_then_count", {20'd0, o_WordCount}, 32'd1);

        // Overflow: 2048 non-HLT words
        reload();
        for (int i = 0; i < 2048; i++) send_word(8'h01, 8'h08, 0);
        check("ovf_error", {31'd0, o_Error}, 32'd1);
        check("ovf_cpu_reset", {31'd0, o_CpuReset}, 32'd1);
        check("ovf_done", {31'd0, o_Done}, 32'd0);
        check("ovf_count", {20'd0, o_WordCount}, 32'd2048);
        for (int i = 0; i < 4; i++) send(8'h00, 0);
        check("ovf_sticky", {31'd0, o_Error}, 32'd1);
        reload();
        check("ovf_reload_error", {31'd0, o_Error}, 32'd0);
        check("ovf_reload_cpu_reset", {31'd0, o_CpuReset}, 32'd1);

        // Asynchronous reset while a write is on the bus
        send(8'h05, 0);
        i_RxData  = 8'h08;
        i_RxValid = 1'b1;
        tick();
        i_RxValid = 1'b0;
        check("pre_rst_we", {31'd0, o_PmWe}, 32'd1);
        i_reset = 1'b1;
        #1;
        check("async_rst_we", {31'd0, o_PmWe}, 32'd0);
        check("async_rst_count", {20'd0, o_WordCount}, 32'd0);
        tick();
        i_reset  = 1'b0;
        exp_addr = '0;
        xor_acc  = '0;
        tick();

`ifdef PROGRAM_LOADER_CKSUM_EN
        // Checksum match and mismatch
        send_word(8'h05, 8'h08, 0);
        send_word(8'h00, 8'h00, 0);
        check("ck_hold", {31'd0, o_CpuReset}, 32'd1);
        send(8'h0D, 0);
        check("ck_ok_done", {31'd0, o_Done}, 32'd1);
        reload();
        send_word(8'h05, 8'h08, 0);
        send_word(8'h00, 8'h00, 0);
        send(8'h0C, 0);
        check("ck_bad_error", {31'd0, o_Error}, 32'd1);
        check("ck_bad_cpu_reset", {31'd0, o_CpuReset}, 32'd1);
`endif

        tick();
        tick();
        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
